ioctl_ram_uploader: RTL and testbench



---
 rtl/ioctl_ram_uploader.sv | 171 +++++++++++++++++
 tb/tb_ioctl_ram_uploader.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ioctl_ram_uploader.sv
// ioctl_ram_uploader: streams SDRAM words to the HPS over the ioctl upload
// handshake, reading through the wishbone port with a 2-word prefetch buffer.
module ioctl_ram_uploader #(
  parameter int ADDR_W = 24
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_upload,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic              ioctl_rd,
  output logic [31:0]       ioctl_din,
  output logic              ioctl_wait,
  output logic              rd_err,
  output logic              wb_cyc,
  output logic              wb_stb,
  output logic              wb_we,
  output logic [3:0]        wb_sel,
  output logic [2:0]        wb_cti,
  output logic [25:0]       wb_adr,
  input  logic [31:0]       wb_dat_i,
  input  logic              wb_ack,
  output logic              active
);

  typedef enum logic [1:0] {IDLE, FETCH, GAP, DRAIN} state_t;

  state_t            state, state_n;
  logic              up_p0, up_p1;
  logic              pend, pend_n;
  logic [ADDR_W-3:0] wptr, wptr_n;
  logic [31:0]       buf0, buf0_n, buf1, buf1_n;
  logic [1:0]        cnt, cnt_n;
  logic              rd_err_n;
  logic              live, rise, push, pop, err_set, flush, start;
  logic              addr_lo_unused;

  // Word pointer to a wishbone byte address, zero-extended to the bus width.
  function automatic logic [25:0] word_to_wb_adr(input logic [ADDR_W-3:0] w);
    logic [ADDR_W-1:0] b;
    b = {w, 2'b00};
    return 26'(b);
  endfunction

  // Fetches are always word aligned, so the byte offset is dropped.
  assign addr_lo_unused = ^ioctl_addr[1:0];

  assign wb_we     = 1'b0;
  assign wb_sel    = 4'hF;
  assign wb_cti    = 3'b000;
  assign ioctl_din = buf0;

  // Next-state, pointer and prefetch-buffer update for this cycle.
  always_comb begin
    state_n  = state;
    pend_n   = pend;
    wptr_n   = wptr;
    buf0_n   = buf0;
    buf1_n   = buf1;
    cnt_n    = cnt;
    push     = 1'b0;
    flush    = 1'b0;
    start    = 1'b0;
    live     = up_p0;
    rise     = up_p0 & ~up_p1;
    pop      = ioctl_rd & (cnt != 2'd0);
    err_set  = ioctl_rd & (cnt == 2'd0);

    case (state)
      IDLE: begin
        pend_n = 1'b0;
        if (up_p0 && (rise || pend)) begin
          start   = 1'b1;
          wptr_n  = ioctl_addr[ADDR_W-1:2];
          state_n = FETCH;
        end
      end
      FETCH: begin
        if (!live) begin
          // Session gone: finish the bus cycle but never keep its data.
          flush   = 1'b1;
          state_n = wb_ack ? IDLE : DRAIN;
        end else if (wb_ack) begin
          push    = 1'b1;
          wptr_n  = wptr + {{(ADDR_W-3){1'b0}}, 1'b1};
          state_n = GAP;
        end
      end
      GAP: begin
        if (!live) begin
          flush   = 1'b1;
          state_n = IDLE;
        end else if ((cnt != 2'd2) || pop) begin
          state_n = FETCH;
        end
      end
      DRAIN: begin
        flush = 1'b1;
        if (rise) pend_n = 1'b1;
        if (wb_ack) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    if (start || flush) begin
      cnt_n = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) buf0_n = wb_dat_i;
          else             buf1_n = wb_dat_i;
          cnt_n = cnt + 2'd1;
        end
        2'b01: begin
          buf0_n = buf1;
          cnt_n  = cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            buf0_n = wb_dat_i;
          end else begin
            buf0_n = buf1;
            buf1_n = wb_dat_i;
          end
        end
        default: ;
      endcase
    end

    rd_err_n = start ? 1'b0 : (rd_err | err_set);
  end

  // --- stage p0/p1: upload edge detect; registered control and outputs ---
  // Control state and all registered outputs.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= IDLE;
      pend       <= 1'b0;
      up_p0      <= 1'b0;
      up_p1      <= 1'b0;
      wptr       <= '0;
      cnt        <= 2'd0;
      buf0       <= 32'd0;
      rd_err     <= 1'b0;
      ioctl_wait <= 1'b0;
      active     <= 1'b0;
      wb_stb     <= 1'b0;
      wb_cyc     <= 1'b0;
      wb_adr     <= 26'd0;
    end else begin
      state      <= state_n;
      pend       <= pend_n;
      up_p0      <= ioctl_upload;
      up_p1      <= up_p0;
      wptr       <= wptr_n;
      cnt        <= cnt_n;
      buf0       <= buf0_n;
      rd_err     <= rd_err_n;
      ioctl_wait <= ioctl_upload & (cnt_n == 2'd0);
      active     <= (state_n != IDLE);
      wb_stb     <= (state_n == FETCH) || (state_n == DRAIN);
      wb_cyc     <= (state_n == FETCH) || (state_n == DRAIN);
      wb_adr     <= word_to_wb_adr(wptr_n);
    end
  end

  // Second prefetch slot; pure data, only meaningful while cnt says so.
  always_ff @(posedge clk_sys) begin
    buf1 <= buf1_n;
  end

endmodule

// File: tb/tb_ioctl_ram_uploader.sv
// Directed bench for ioctl_ram_uploader with a small wishbone slave model.
module tb_ioctl_ram_uploader;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_upload;
  logic [23:0] ioctl_addr;
  logic        ioctl_rd;
  logic [31:0] ioctl_din;
  logic        ioctl_wait;
  logic        rd_err;
  logic        wb_cyc, wb_stb, wb_we;
  logic [3:0]  wb_sel;
  logic [2:0]  wb_cti;
  logic [25:0] wb_adr;
  logic [31:0] wb_dat_i = 32'd0;
  logic        wb_ack = 1'b0;
  logic        active;

  int checks = 0;
  int errors = 0;
  int lat = 3;
  int scnt = 0;
  int stb_rises = 0;
  logic stb_q = 1'b0;

  ioctl_ram_uploader #(.ADDR_W(24)) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_upload(ioctl_upload),
    .ioctl_addr(ioctl_addr), .ioctl_rd(ioctl_rd), .ioctl_din(ioctl_din),
    .ioctl_wait(ioctl_wait), .rd_err(rd_err), .wb_cyc(wb_cyc), .wb_stb(wb_stb),
    .wb_we(wb_we), .wb_sel(wb_sel), .wb_cti(wb_cti), .wb_adr(wb_adr),
    .wb_dat_i(wb_dat_i), .wb_ack(wb_ack), .active(active)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic logic [31:0] mem_word(input logic [25:0] a);
    if (a == 26'h001000) return 32'h11223344;
    return 32'hA5000000 | {8'h00, a[23:0]};
  endfunction

  // Slave: ack arrives lat cycles after the strobe is first seen.
  always @(posedge clk_sys) begin
    if (wb_ack) begin
      wb_ack <= 1'b0;
      scnt   <= 0;
    end else if (wb_stb && wb_cyc) begin
      if (scnt + 1 >= lat) begin
        wb_ack   <= 1'b1;
        wb_dat_i <= mem_word(wb_adr);
        scnt     <= 0;
      end else begin
        scnt <= scnt + 1;
      end
    end else begin
      scnt <= 0;
    end
  end

  // Count bus read starts.
  always @(posedge clk_sys) begin
    stb_q <= wb_stb;
    if (wb_stb && !stb_q) stb_rises <= stb_rises + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    int base;
    reset = 1'b1; ioctl_upload = 1'b0; ioctl_addr = 24'd0; ioctl_rd = 1'b0;
    tick(3);
    chk("rst_stb", 32'(wb_stb), 0);
    chk("rst_cyc", 32'(wb_cyc), 0);
    chk("rst_active", 32'(active), 0);
    chk("rst_wait", 32'(ioctl_wait), 0);
    chk("rst_rd_err", 32'(rd_err), 0);
    chk("rst_din", ioctl_din, 0);
    chk("rst_adr", 32'(wb_adr), 0);
    chk("const_we", 32'(wb_we), 0);
    chk("const_sel", 32'(wb_sel), 32'hF);
    chk("const_cti", 32'(wb_cti), 0);
    reset = 1'b0;
    tick(2);

    // Session 1: unaligned start, latency 3, no reads for a while.
    base = stb_rises;
    ioctl_addr = 24'h001003; ioctl_upload = 1'b1;
    tick(1);
    chk("s1_stb_not_yet", 32'(wb_stb), 0);
    chk("s1_wait_high", 32'(ioctl_wait), 1);
    tick(1);
    chk("s1_stb_up", 32'(wb_stb), 1);
    chk("s1_cyc_up", 32'(wb_cyc), 1);
    chk("s1_adr0", 32'(wb_adr), 32'h1000);
    chk("s1_active", 32'(active), 1);
    tick(3);
    chk("s1_wait_before_ack", 32'(ioctl_wait), 1);
    tick(1);
    chk("s1_wait_drop", 32'(ioctl_wait), 0);
    chk("s1_din0", ioctl_din, 32'h11223344);
    chk("s1_stb_gap", 32'(wb_stb), 0);
    tick(1);
    chk("s1_stb_second", 32'(wb_stb), 1);
    chk("s1_adr1", 32'(wb_adr), 32'h1004);
    tick(24);
    chk("s1_read_count", 32'(stb_rises - base), 2);
    chk("s1_bus_idle", 32'(wb_stb), 0);
    chk("s1_active_hold", 32'(active), 1);
    chk("s1_din_hold", ioctl_din, 32'h11223344);
    ioctl_rd = 1'b1;
    tick(1);
    ioctl_rd = 1'b0;
    chk("s1_pop_din", ioctl_din, 32'hA5001004);
    chk("s1_refetch_stb", 32'(wb_stb), 1);
    chk("s1_refetch_adr", 32'(wb_adr), 32'h1008);
    chk("s1_rd_err_clear", 32'(rd_err), 0);
    tick(4);
    chk("s1_refetch_done", 32'(wb_stb), 0);
    chk("s1_din_after", ioctl_din, 32'hA5001004);
    ioctl_upload = 1'b0;
    tick(2);
    chk("s1_end_active", 32'(active), 0);
    chk("s1_end_wait", 32'(ioctl_wait), 0);
    tick(3);

    // Session 2: wrap at the top of the address space, latency 1.
    lat = 1;
    ioctl_addr = 24'hFFFFFC; ioctl_upload = 1'b1;
    tick(2);
    chk("s2_adr0", 32'(wb_adr), 32'hFFFFFC);
    tick(2);
    chk("s2_din0", ioctl_din, 32'hA5FFFFFC);
    chk("s2_wait", 32'(ioctl_wait), 0);
    tick(1);
    chk("s2_stb_second", 32'(wb_stb), 1);
    chk("s2_adr_wrap", 32'(wb_adr), 0);
    ioctl_upload = 1'b0;
    tick(3);
    chk("s2_end_active", 32'(active), 0);
    chk("s2_end_stb", 32'(wb_stb), 0);
    tick(3);

    // Session 3: read strobe coincides with the first ack.
    lat = 3;
    ioctl_addr = 24'h001000; ioctl_upload = 1'b1;
    tick(5);
    ioctl_rd = 1'b1;
    tick(1);
    ioctl_rd = 1'b0;
    chk("s3_rd_err", 32'(rd_err), 1);
    chk("s3_din_kept", ioctl_din, 32'h11223344);
    chk("s3_wait", 32'(ioctl_wait), 0);
    tick(2);
    ioctl_upload = 1'b0;
    n = 0;
    while (active !== 1'b0 && n < 30) begin
      tick(1);
      n++;
    end
    chk("s3_drain_done", 32'(active), 0);
    chk("s3_rd_err_sticky", 32'(rd_err), 1);
    tick(3);

    // Session 4: drop mid-fetch with latency 4, re-raise during the drain.
    lat = 4;
    ioctl_addr = 24'h002000; ioctl_upload = 1'b1;
    tick(2);
    chk("s4_stb", 32'(wb_stb), 1);
    chk("s4_adr", 32'(wb_adr), 32'h2000);
    ioctl_upload = 1'b0;
    tick(2);
    chk("s4_drain_stb", 32'(wb_stb), 1);
    chk("s4_drain_cyc", 32'(wb_cyc), 1);
    chk("s4_drain_active", 32'(active), 1);
    ioctl_addr = 24'h003000; ioctl_upload = 1'b1;
    tick(2);
    chk("s4_drain_stb2", 32'(wb_stb), 1);
    chk("s4_drain_wait", 32'(ioctl_wait), 1);
    tick(1);
    chk("s4_idle_stb", 32'(wb_stb), 0);
    chk("s4_idle_active", 32'(active), 0);
    lat = 2;
    tick(1);
    chk("s4_new_stb", 32'(wb_stb), 1);
    chk("s4_new_adr", 32'(wb_adr), 32'h3000);
    chk("s4_rd_err_cleared", 32'(rd_err), 0);
    tick(2);
    chk("s4_new_wait", 32'(ioctl_wait), 1);
    tick(1);
    chk("s4_new_wait_drop", 32'(ioctl_wait), 0);
    chk("s4_new_din", ioctl_din, 32'hA5003000);

    // Reset in the middle of a fetch.
    tick(1);
    chk("s5_pre_stb", 32'(wb_stb), 1);
    reset = 1'b1;
    tick(1);
    chk("s5_stb", 32'(wb_stb), 0);
    chk("s5_cyc", 32'(wb_cyc), 0);
    chk("s5_active", 32'(active), 0);
    chk("s5_wait", 32'(ioctl_wait), 0);
    chk("s5_rd_err", 32'(rd_err), 0);
    chk("s5_din", ioctl_din, 0);
    reset = 1'b0; ioctl_upload = 1'b0;
    tick(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
